// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-requester arbiter for the 16x8 register file
// Round-robin grant in IDLE with a bounded lock mode for atomic multi-beat sequences.
module regfile_arbiter #(
  parameter int MAX_LOCK = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req0_we,
  input  logic [3:0] req0_addr_a,
  input  logic [3:0] req0_addr_b,
  input  logic [7:0] req0_wdata,
  input  logic       req0_lock,
  output logic       req0_ready,
  output logic       req0_rvalid,
  output logic [7:0] req0_rdata_a,
  output logic [7:0] req0_rdata_b,
  input  logic       req1_valid,
  input  logic       req1_we,
  input  logic [3:0] req1_addr_a,
  input  logic [3:0] req1_addr_b,
  input  logic [7:0] req1_wdata,
  input  logic       req1_lock,
  output logic       req1_ready,
  output logic       req1_rvalid,
  output logic [7:0] req1_rdata_a,
  output logic [7:0] req1_rdata_b,
  output logic       rf_reg_write,
  output logic [3:0] rf_rd,
  output logic [3:0] rf_rs1,
  output logic [3:0] rf_rs2,
  output logic [7:0] rf_write_data,
  input  logic [7:0] rf_out_rs1,
  input  logic [7:0] rf_out_rs2,
  output logic       lock_timeout
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] LOCK_LAST = 4'(MAX_LOCK - 1);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic       lock_timeout_q, lock_timeout_d;
  logic       rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [7:0] rdata_a0_q, rdata_a0_d, rdata_b0_q, rdata_b0_d;
  logic [7:0] rdata_a1_q, rdata_a1_d, rdata_b1_q, rdata_b1_d;
  logic       grant0, grant1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      last_q         <= 1'b1;
      lock_cnt_q     <= 4'd0;
      lock_timeout_q <= 1'b0;
      rvalid0_q      <= 1'b0;
      rvalid1_q      <= 1'b0;
      rdata_a0_q     <= 8'h00;
      rdata_b0_q     <= 8'h00;
      rdata_a1_q     <= 8'h00;
      rdata_b1_q     <= 8'h00;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      lock_cnt_q     <= lock_cnt_d;
      lock_timeout_q <= lock_timeout_d;
      rvalid0_q      <= rvalid0_d;
      rvalid1_q      <= rvalid1_d;
      rdata_a0_q     <= rdata_a0_d;
      rdata_b0_q     <= rdata_b0_d;
      rdata_a1_q     <= rdata_a1_d;
      rdata_b1_q     <= rdata_b1_d;
    end
  end

  // Timeout takes priority; otherwise dropping lock leaves OWNk whether or not a beat is granted.
  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    lock_cnt_d     = lock_cnt_q;
    lock_timeout_d = 1'b0;
    if (grant0) last_d = 1'b0;
    if (grant1) last_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (grant0 && req0_lock) begin
          state_d    = OWN0;
          lock_cnt_d = 4'd0;
        end else if (grant1 && req1_lock) begin
          state_d    = OWN1;
          lock_cnt_d = 4'd0;
        end
      end
      OWN0: begin
        if (lock_cnt_q == LOCK_LAST) begin
          state_d        = IDLE;
          lock_timeout_d = 1'b1;
          last_d         = 1'b0;
        end else if (!req0_lock) begin
          state_d = IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + 4'd1;
        end
      end
      OWN1: begin
        if (lock_cnt_q == LOCK_LAST) begin
          state_d        = IDLE;
          lock_timeout_d = 1'b1;
          last_d         = 1'b1;
        end else if (!req1_lock) begin
          state_d = IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state_q)
      IDLE: begin
        grant0 = req0_valid && (!req1_valid || last_q);
        grant1 = req1_valid && (!req0_valid || !last_q);
      end
      OWN0:    grant0 = req0_valid;
      OWN1:    grant1 = req1_valid;
      default: ;
    endcase
    if (reset) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
    rf_reg_write  = 1'b0;
    rf_rd         = 4'd0;
    rf_rs1        = 4'd0;
    rf_rs2        = 4'd0;
    rf_write_data = 8'h00;
    if (grant0) begin
      rf_reg_write  = req0_we;
      rf_rd         = req0_addr_a;
      rf_rs1        = req0_addr_a;
      rf_rs2        = req0_addr_b;
      rf_write_data = req0_wdata;
    end else if (grant1) begin
      rf_reg_write  = req1_we;
      rf_rd         = req1_addr_a;
      rf_rs1        = req1_addr_a;
      rf_rs2        = req1_addr_b;
      rf_write_data = req1_wdata;
    end
    rvalid0_d  = grant0 && !req0_we;
    rvalid1_d  = grant1 && !req1_we;
    rdata_a0_d = rvalid0_d ? rf_out_rs1 : rdata_a0_q;
    rdata_b0_d = rvalid0_d ? rf_out_rs2 : rdata_b0_q;
    rdata_a1_d = rvalid1_d ? rf_out_rs1 : rdata_a1_q;
    rdata_b1_d = rvalid1_d ? rf_out_rs2 : rdata_b1_q;
  end

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign req0_rvalid  = rvalid0_q;
  assign req1_rvalid  = rvalid1_q;
  assign req0_rdata_a = rdata_a0_q;
  assign req0_rdata_b = rdata_b0_q;
  assign req1_rdata_a = rdata_a1_q;
  assign req1_rdata_b = rdata_b1_q;
  assign lock_timeout = lock_timeout_q;

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester arbiter for the 16 x 8-bit register file. It lets the instruction datapath (requester 0) and the key-load/key-schedule engine (requester 1) share the register file's single write port and its dual read port. The block owns every regfile control input and grants at most one transaction per cycle. A bounded lock mode lets one requester perform an atomic multi-beat sequence, such as reading a key byte, transforming it and writing it back.

## Interface

Parameters:
- `MAX_LOCK`, default 4: maximum number of cycles spent in a lock-owner state before forced release. Legal range is 1 to 15.

Ports (`k` = 0, 1):
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high
- `reqk_valid`  in  1  request present. The request fields below must be held stable until `reqk_ready`.
- `reqk_we`  in  1  1 = write, 0 = read
- `reqk_addr_a`  in  4  write: destination register. Read: first source register.
- `reqk_addr_b`  in  4  read: second source register. Ignored on a write.
- `reqk_wdata`  in  8  write data
- `reqk_lock`  in  1  request or keep exclusive ownership after this beat
- `reqk_ready`  out  1  grant (combinational); a transaction occurs when valid & ready
- `reqk_rvalid`  out  1  read data valid (registered, one-cycle pulse)
- `reqk_rdata_a`  out  8  registered data for `addr_a`
- `reqk_rdata_b`  out  8  registered data for `addr_b`
- `rf_reg_write`  out  1  to regfile `reg_write`
- `rf_rd`  out  4  to regfile `rd`
- `rf_rs1`  out  4  to regfile `rs1`
- `rf_rs2`  out  4  to regfile `rs2`
- `rf_write_data`  out  8  to regfile `write_data`
- `rf_out_rs1`  in  8  from regfile, combinational read
- `rf_out_rs2`  in  8  from regfile, combinational read
- `lock_timeout`  out  1  one-cycle pulse on forced lock release

## Operation

- **States:** IDLE, OWN0, OWN1. Registered state also includes `last` (the requester granted most recently), `lock_cnt` (4 bits) and the read-return registers.
- **Reset values:** state = IDLE, `last` = 1 (so requester 0 wins the first tie), `lock_cnt` = 0. All `rvalid`, `rdata_a`, `rdata_b` and `lock_timeout` outputs are 0.
- **IDLE arbitration:**
  - One requester valid: it is granted.
  - Both valid: the requester not equal to `last` is granted (round-robin).
  - `last` updates only when a grant occurs.
- **OWNk:** only requester k may be granted, and only when `reqk_valid` is high. `reqj_ready` (the other requester) is held at 0.
- **Regfile drive from the granted request:**
  - `rf_rd` = `addr_a`, `rf_rs1` = `addr_a`, `rf_rs2` = `addr_b`, `rf_write_data` = `wdata`.
  - `rf_reg_write` = grant & `we`.
  - With no grant, all `rf_*` outputs are 0.
- **Read return:** on a granted read, `rf_out_rs1` and `rf_out_rs2` are captured into the winner's `rdata_a` and `rdata_b` at that edge, and the winner's `rvalid` is 1 for the following cycle. `rdata` holds its value until the next read by that requester.
- **State transitions (evaluated at each edge):**
  - IDLE to OWNk: requester k granted with `reqk_lock` = 1. `lock_cnt` is set to 0.
  - OWNk to IDLE, normal exit, on either condition:
    - a granted beat with `reqk_lock` = 0, or
    - `reqk_valid` = 0 and `reqk_lock` = 0 (abandon).
  - OWNk to IDLE, timeout exit: `lock_cnt` == MAX_LOCK-1. `lock_timeout` is 1 in the next cycle and `last` = k. This exit takes priority over staying in OWNk.
  - Otherwise remain in OWNk and increment `lock_cnt`.
- A single lock can therefore cover at most 1 + MAX_LOCK cycles: the entry beat in IDLE plus MAX_LOCK cycles in OWNk.

## Timing

- Grant and ready are combinational from the valid inputs and the registered state, in the same cycle.
- Writes commit at the grant edge.
- Read data is taken from the register file as it stands before the grant edge, so it includes every earlier granted write. It appears with `rvalid` exactly one cycle after the grant.
- Throughput: one transaction per cycle in total. Under continuous contention in IDLE, grants alternate 0,1,0,1.
- Reset asserted mid-operation, including mid-lock: all registered outputs and state return to their reset values immediately. `ready` is 0 while reset is high. Any pending `rvalid` is dropped.

## Test plan

- **Write then read:** after reset, req0 writes r3 = 0xA5; next cycle req0 reads a=3, b=0. Required: `rf_reg_write` = 1 for one cycle; one cycle after the read grant, `req0_rvalid` = 1, `rdata_a` = 0xA5, `rdata_b` = 0x00.
- **Round-robin:** both requesters issue continuous reads from cycle 0. Required grant order 0,1,0,1,0,1, with each `rvalid` arriving one cycle after its own grant.
- **Write visibility across requesters:** in the same cycle, req1 writes r5 = 0x3C and req0 reads r5. Tie order is 0 then 1, so req0 reads 0x00 first. Repeat with `last` = 0: req1's write is granted first, req0 is granted the next cycle and reads 0x3C.
- **Lock:** req1 issues 3 beats with lock = 1,1,0 while req0 is valid throughout. Required: `req0_ready` = 0 for all 3 beats, then req0 is granted in the next cycle and `lock_timeout` stays 0.
- **Lock timeout:** MAX_LOCK = 4; req0 holds lock = 1 with continuous valid while req1 is valid. Required: req0 is granted for 5 consecutive cycles, then `lock_timeout` pulses for one cycle and req1 is granted in that same cycle.
- **Reset during lock:** assert reset in OWN1 with an `rvalid` pending. Required: all outputs go to 0 immediately and state is IDLE; after release, the first tie is granted to req0.
